// File: rtl/ats21_pkg.sv
// Shared ATS21 definitions: opcodes, issuer FSM states, and the bit layout of
// the response word.
package ats21_pkg;

   localparam int unsigned CMD_W   = 32;
   localparam int unsigned LANE_W  = 16;
   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 29;

   typedef enum logic [2:0] {
      ATS_NOP     = 3'd0,
      ATS_SET_CLK = 3'd1,
      ATS_EN_CLK  = 3'd2,
      ATS_MODE    = 3'd3,
      ATS_SET_ALM = 3'd4,
      ATS_SET_TMR = 3'd5,
      ATS_EN_ALM  = 3'd6
   } ats_opc_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HI   = 3'd1,
      S_LO   = 3'd2,
      S_WAIT = 3'd3,
      S_RESP = 3'd4
   } ats_state_e;

   // resp = {b_issued, b_ack, a_issued, a_ack}
   localparam int unsigned RESP_A_ACK = 0;
   localparam int unsigned RESP_A_ISS = 1;
   localparam int unsigned RESP_B_ACK = 2;
   localparam int unsigned RESP_B_ISS = 3;

   function automatic logic [2:0] cmd_opcode(input logic [CMD_W-1:0] cmd);
      return cmd[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/ats_cmd_issuer_if.sv
// Client, ATS21 instruction and response signals of the command issuer.
// The issuer takes the slave view; whoever drives clients and the ATS21 takes master.
interface ats_cmd_issuer_if;

   logic        a_valid;
   logic [31:0] a_cmd;
   logic        a_ready;
   logic        b_valid;
   logic [31:0] b_cmd;
   logic        b_ready;
   logic        req;
   logic [15:0] ctrlA;
   logic [15:0] ctrlB;
   logic [1:0]  stat;
   logic        resp_valid;
   logic        resp_ready;
   logic [3:0]  resp;

   modport slave (
      input  a_valid, a_cmd, b_valid, b_cmd, stat, resp_ready,
      output a_ready, b_ready, req, ctrlA, ctrlB, resp_valid, resp
   );

   modport master (
      output a_valid, a_cmd, b_valid, b_cmd, stat, resp_ready,
      input  a_ready, b_ready, req, ctrlA, ctrlB, resp_valid, resp
   );

endinterface

// File: rtl/ats_cmd_slot.sv
// One-deep command holding register. Loads on in_valid && in_ready and empties on free.
module ats_cmd_slot
   import ats21_pkg::*;
(
   input  logic             clk_1x,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [CMD_W-1:0] in_cmd,
   input  logic             free,
   output logic             in_ready,
   output logic             full,
   output logic [CMD_W-1:0] cmd
);

   logic             full_q, full_d;
   logic [CMD_W-1:0] cmd_q, cmd_d;
   logic             load;

   // ready is held low while reset is asserted, not only when the slot is full
   assign in_ready = ~full_q & ~reset;
   assign load     = in_valid & in_ready;

   always_comb begin
      full_d = full_q;
      cmd_d  = cmd_q;
      if (free) begin
         full_d = 1'b0;
      end
      if (load) begin
         full_d = 1'b1;
         cmd_d  = in_cmd;
      end
   end

   always_ff @(posedge clk_1x or posedge reset) begin
      if (reset) begin
         full_q <= 1'b0;
         cmd_q  <= '0;
      end else begin
         full_q <= full_d;
         cmd_q  <= cmd_d;
      end
   end

   assign full = full_q;
   assign cmd  = cmd_q;

endmodule

// File: rtl/ats_cmd_issuer.sv
// Arbitration-free ATS21 command issuer: both full client slots launch together and are
// sent as HI/LO half-words, then stat is sampled and the result is offered to the consumer.
//
// state | meaning
// IDLE  | no transaction; leave as soon as either slot holds a command
// HI    | req high, launched lanes carry cmd[31:16]
// LO    | req high, launched lanes carry cmd[15:0]
// WAIT  | STAT_LAT cycles for the ATS21 to answer; launched slots already freed
// RESP  | resp_valid high, resp held until resp_ready
module ats_cmd_issuer
   import ats21_pkg::*;
#(
   parameter int unsigned STAT_LAT = 1,
   parameter logic [2:0]  OPC_NOP  = 3'b000
) (
   input logic            clk_1x,
   input logic            reset,
   ats_cmd_issuer_if.slave bus
);

   localparam logic [2:0] ST_IDLE   = 3'(S_IDLE);
   localparam logic [2:0] ST_HI     = 3'(S_HI);
   localparam logic [2:0] ST_LO     = 3'(S_LO);
   localparam logic [2:0] ST_WAIT   = 3'(S_WAIT);
   localparam logic [2:0] ST_RESP   = 3'(S_RESP);
   localparam logic [1:0] WAIT_INIT = 2'(STAT_LAT - 1);

   logic             a_ready, b_ready;
   logic             full_a, full_b;
   logic             free_a, free_b;
   logic [CMD_W-1:0] cmd_a, cmd_b;

   logic [2:0] state_q, state_d;
   logic       launch_a_q, launch_a_d;
   logic       launch_b_q, launch_b_d;
   logic       issue_a_q, issue_a_d;
   logic       issue_b_q, issue_b_d;
   logic [1:0] wait_cnt_q, wait_cnt_d;
   logic [3:0] resp_q, resp_d;

   logic              req;
   logic [LANE_W-1:0] ctrl_a, ctrl_b;

   ats_cmd_slot u_slot_a (
      .clk_1x   (clk_1x),
      .reset    (reset),
      .in_valid (bus.a_valid),
      .in_cmd   (bus.a_cmd),
      .free     (free_a),
      .in_ready (a_ready),
      .full     (full_a),
      .cmd      (cmd_a)
   );

   ats_cmd_slot u_slot_b (
      .clk_1x   (clk_1x),
      .reset    (reset),
      .in_valid (bus.b_valid),
      .in_cmd   (bus.b_cmd),
      .free     (free_b),
      .in_ready (b_ready),
      .full     (full_b),
      .cmd      (cmd_b)
   );

   always_comb begin
      state_d    = state_q;
      launch_a_d = launch_a_q;
      launch_b_d = launch_b_q;
      issue_a_d  = issue_a_q;
      issue_b_d  = issue_b_q;
      wait_cnt_d = wait_cnt_q;
      resp_d     = resp_q;
      free_a     = 1'b0;
      free_b     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // snapshot which slots ride this transaction; later arrivals wait
            if (full_a || full_b) begin
               state_d    = ST_HI;
               launch_a_d = full_a;
               launch_b_d = full_b;
               issue_a_d  = full_a && (cmd_opcode(cmd_a) != OPC_NOP);
               issue_b_d  = full_b && (cmd_opcode(cmd_b) != OPC_NOP);
            end
         end
         ST_HI: begin
            state_d = ST_LO;
         end
         ST_LO: begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_INIT;
            free_a     = launch_a_q;
            free_b     = launch_b_q;
         end
         ST_WAIT: begin
            if (wait_cnt_q == 2'd0) begin
               state_d            = ST_RESP;
               resp_d[RESP_A_ACK] = issue_a_q & bus.stat[0];
               resp_d[RESP_A_ISS] = issue_a_q;
               resp_d[RESP_B_ACK] = issue_b_q & bus.stat[1];
               resp_d[RESP_B_ISS] = issue_b_q;
            end else begin
               wait_cnt_d = wait_cnt_q - 2'd1;
            end
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               state_d    = ST_IDLE;
               resp_d     = '0;
               launch_a_d = 1'b0;
               launch_b_d = 1'b0;
               issue_a_d  = 1'b0;
               issue_b_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_1x or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         launch_a_q <= 1'b0;
         launch_b_q <= 1'b0;
         issue_a_q  <= 1'b0;
         issue_b_q  <= 1'b0;
         wait_cnt_q <= '0;
         resp_q     <= '0;
      end else begin
         state_q    <= state_d;
         launch_a_q <= launch_a_d;
         launch_b_q <= launch_b_d;
         issue_a_q  <= issue_a_d;
         issue_b_q  <= issue_b_d;
         wait_cnt_q <= wait_cnt_d;
         resp_q     <= resp_d;
      end
   end

   // A transaction made only of no-ops never raises req
   always_comb begin
      req    = 1'b0;
      ctrl_a = '0;
      ctrl_b = '0;
      if (state_q == ST_HI) begin
         req    = issue_a_q | issue_b_q;
         ctrl_a = issue_a_q ? cmd_a[31:16] : '0;
         ctrl_b = issue_b_q ? cmd_b[31:16] : '0;
      end else if (state_q == ST_LO) begin
         req    = issue_a_q | issue_b_q;
         ctrl_a = issue_a_q ? cmd_a[15:0] : '0;
         ctrl_b = issue_b_q ? cmd_b[15:0] : '0;
      end
   end

   assign bus.a_ready    = a_ready;
   assign bus.b_ready    = b_ready;
   assign bus.req        = req;
   assign bus.ctrlA      = ctrl_a;
   assign bus.ctrlB      = ctrl_b;
   assign bus.resp_valid = (state_q == ST_RESP);
   assign bus.resp       = resp_q;

endmodule

// File: tb/tb_ats_cmd_issuer.sv
// Directed bench for ats_cmd_issuer: table of single transactions plus hand-written
// sequences for stall, mid-transaction reset and late-arriving commands.
module tb_ats_cmd_issuer;

   localparam int unsigned TB_LAT = 2;

   logic clk_1x;
   logic reset;
   int   n_chk;
   int   n_fail;

   ats_cmd_issuer_if bus ();

   ats_cmd_issuer #(
      .STAT_LAT (TB_LAT),
      .OPC_NOP  (3'b000)
   ) dut (
      .clk_1x (clk_1x),
      .reset  (reset),
      .bus    (bus)
   );

   initial clk_1x = 1'b0;
   always #5 clk_1x = ~clk_1x;

   typedef struct {
      logic        a_v;
      logic [31:0] a_cmd;
      logic        b_v;
      logic [31:0] b_cmd;
      logic [1:0]  stat;
      logic        exp_req;
      logic [15:0] a_hi;
      logic [15:0] a_lo;
      logic [15:0] b_hi;
      logic [15:0] b_lo;
      logic [3:0]  exp_resp;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_1x);
      #1;
   endtask

   task automatic wait_phase();
      for (int w = 0; w < int'(TB_LAT); w++) begin
         tick();
         chk("wait_req", 32'(bus.req), 32'd0);
         chk("wait_ctrlA", 32'(bus.ctrlA), 32'd0);
         chk("wait_resp_valid", 32'(bus.resp_valid), 32'd0);
      end
   endtask

   task automatic run_vec(input vec_t v);
      bus.a_valid = v.a_v;
      bus.a_cmd   = v.a_cmd;
      bus.b_valid = v.b_v;
      bus.b_cmd   = v.b_cmd;
      bus.stat    = v.stat;
      tick();
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      chk("load_a_ready", 32'(bus.a_ready), 32'(!v.a_v));
      chk("load_b_ready", 32'(bus.b_ready), 32'(!v.b_v));
      tick();
      chk("hi_req", 32'(bus.req), 32'(v.exp_req));
      chk("hi_ctrlA", 32'(bus.ctrlA), 32'(v.a_hi));
      chk("hi_ctrlB", 32'(bus.ctrlB), 32'(v.b_hi));
      tick();
      chk("lo_req", 32'(bus.req), 32'(v.exp_req));
      chk("lo_ctrlA", 32'(bus.ctrlA), 32'(v.a_lo));
      chk("lo_ctrlB", 32'(bus.ctrlB), 32'(v.b_lo));
      wait_phase();
      chk("wait_a_ready", 32'(bus.a_ready), 32'd1);
      chk("wait_b_ready", 32'(bus.b_ready), 32'd1);
      tick();
      chk("resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("resp", 32'(bus.resp), 32'(v.exp_resp));
      tick();
      chk("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("idle_req", 32'(bus.req), 32'd0);
      chk("idle_a_ready", 32'(bus.a_ready), 32'd1);
      chk("idle_b_ready", 32'(bus.b_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;

      //             a_v   a_cmd         b_v   b_cmd         stat   req   a_hi      a_lo      b_hi      b_lo      resp
      vecs[0] = '{1'b1, 32'h2200_0005, 1'b0, 32'h0000_0000, 2'b01, 1'b1, 16'h2200, 16'h0005, 16'h0000, 16'h0000, 4'b0011};
      vecs[1] = '{1'b1, 32'hA301_0010, 1'b1, 32'hA401_0020, 2'b11, 1'b1, 16'hA301, 16'h0010, 16'hA401, 16'h0020, 4'b1111};
      vecs[2] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_1234, 2'b11, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000};
      vecs[3] = '{1'b1, 32'h2200_0005, 1'b0, 32'h0000_0000, 2'b00, 1'b1, 16'h2200, 16'h0005, 16'h0000, 16'h0000, 4'b0010};
      vecs[4] = '{1'b0, 32'h0000_0000, 1'b1, 32'hA401_0020, 2'b10, 1'b1, 16'h0000, 16'h0000, 16'hA401, 16'h0020, 4'b1100};
      vecs[5] = '{1'b1, 32'h0000_00FF, 1'b1, 32'h6000_0001, 2'b01, 1'b1, 16'h0000, 16'h0000, 16'h6000, 16'h0001, 4'b1000};
      vecs[6] = '{1'b1, 32'hE000_ABCD, 1'b1, 32'h2000_0000, 2'b10, 1'b1, 16'hE000, 16'hABCD, 16'h2000, 16'h0000, 4'b1110};

      reset          = 1'b1;
      bus.a_valid    = 1'b0;
      bus.a_cmd      = '0;
      bus.b_valid    = 1'b0;
      bus.b_cmd      = '0;
      bus.stat       = 2'b00;
      bus.resp_ready = 1'b1;

      // reset state
      tick();
      tick();
      chk("rst_req", 32'(bus.req), 32'd0);
      chk("rst_ctrlA", 32'(bus.ctrlA), 32'd0);
      chk("rst_ctrlB", 32'(bus.ctrlB), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp", 32'(bus.resp), 32'd0);
      chk("rst_a_ready", 32'(bus.a_ready), 32'd0);
      chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
      reset = 1'b0;
      tick();
      chk("post_rst_a_ready", 32'(bus.a_ready), 32'd1);
      chk("post_rst_b_ready", 32'(bus.b_ready), 32'd1);

      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i]);
      end

      // resp_ready stall with a new A command loading during RESP
      bus.resp_ready = 1'b0;
      bus.a_valid    = 1'b1;
      bus.a_cmd      = 32'h2200_0005;
      bus.stat       = 2'b01;
      tick();
      bus.a_valid = 1'b0;
      tick();
      chk("stall_hi_ctrlA", 32'(bus.ctrlA), 32'h2200);
      tick();
      wait_phase();
      tick();
      chk("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("stall_resp", 32'(bus.resp), 32'h3);
      bus.a_valid = 1'b1;
      bus.a_cmd   = 32'h4800_1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         bus.a_valid = 1'b0;
         bus.stat    = 2'b00;
         chk("stall_hold_valid", 32'(bus.resp_valid), 32'd1);
         chk("stall_hold_resp", 32'(bus.resp), 32'h3);
         chk("stall_hold_req", 32'(bus.req), 32'd0);
         chk("stall_a_loaded", 32'(bus.a_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
      bus.stat       = 2'b01;
      tick();
      chk("stall_release_valid", 32'(bus.resp_valid), 32'd0);
      tick();
      chk("stall_next_hi_req", 32'(bus.req), 32'd1);
      chk("stall_next_hi_ctrlA", 32'(bus.ctrlA), 32'h4800);
      tick();
      chk("stall_next_lo_ctrlA", 32'(bus.ctrlA), 32'h1111);
      wait_phase();
      tick();
      chk("stall_next_resp", 32'(bus.resp), 32'h3);
      tick();

      // reset pulse during LO abandons the transaction
      bus.a_valid = 1'b1;
      bus.a_cmd   = 32'h2200_0005;
      bus.b_valid = 1'b1;
      bus.b_cmd   = 32'hA401_0020;
      tick();
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      tick();
      tick();
      chk("rstmid_lo_req", 32'(bus.req), 32'd1);
      chk("rstmid_lo_ctrlB", 32'(bus.ctrlB), 32'h0020);
      reset = 1'b1;
      tick();
      chk("rstmid_req", 32'(bus.req), 32'd0);
      chk("rstmid_ctrlA", 32'(bus.ctrlA), 32'd0);
      chk("rstmid_ctrlB", 32'(bus.ctrlB), 32'd0);
      chk("rstmid_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rstmid_a_ready", 32'(bus.a_ready), 32'd0);
      reset = 1'b0;
      tick();
      chk("rstmid_a_empty", 32'(bus.a_ready), 32'd1);
      chk("rstmid_b_empty", 32'(bus.b_ready), 32'd1);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rstmid_no_req", 32'(bus.req), 32'd0);
         chk("rstmid_no_resp", 32'(bus.resp_valid), 32'd0);
      end

      // A offered during HI of a B-only transaction waits for the next one
      bus.b_valid = 1'b1;
      bus.b_cmd   = 32'hA401_0020;
      bus.stat    = 2'b10;
      tick();
      bus.b_valid = 1'b0;
      tick();
      chk("late_hi_ctrlB", 32'(bus.ctrlB), 32'hA401);
      chk("late_hi_ctrlA", 32'(bus.ctrlA), 32'd0);
      bus.a_valid = 1'b1;
      bus.a_cmd   = 32'h2200_0005;
      tick();
      bus.a_valid = 1'b0;
      chk("late_lo_ctrlA", 32'(bus.ctrlA), 32'd0);
      chk("late_lo_ctrlB", 32'(bus.ctrlB), 32'h0020);
      chk("late_a_held", 32'(bus.a_ready), 32'd0);
      wait_phase();
      chk("late_a_not_freed", 32'(bus.a_ready), 32'd0);
      tick();
      chk("late_b_resp", 32'(bus.resp), 32'hC);
      bus.stat = 2'b01;
      tick();
      tick();
      chk("late_next_hi_ctrlA", 32'(bus.ctrlA), 32'h2200);
      chk("late_next_hi_ctrlB", 32'(bus.ctrlB), 32'd0);
      tick();
      chk("late_next_lo_ctrlA", 32'(bus.ctrlA), 32'h0005);
      wait_phase();
      tick();
      chk("late_next_resp", 32'(bus.resp), 32'h3);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ats_cmd_issuer.md
ATS_CMD_ISSUER -- requirements
Module: ats_cmd_issuer

Interface
REQ-001 SHALL have parameter STAT_LAT, default 1: number of cycles after the LO half before stat is sampled (range 1-4).
REQ-002 SHALL have parameter OPC_NOP, default 3'b000: opcode that marks a command as a no-op.
REQ-003 SHALL have port clk_1x  in  1: clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1: reset, asynchronous, active-high.
REQ-005 SHALL have ports a_valid/b_valid  in  1: client A/B command offered.
REQ-006 SHALL have ports a_cmd/b_cmd  in  32: client command word; opcode is bits [31:29].
REQ-007 SHALL have ports a_ready/b_ready  out  1: high when that client's holding slot is empty.
REQ-008 SHALL have port req  out  1: instruction request to the ATS21.
REQ-009 SHALL have ports ctrlA/ctrlB  out  16: ATS21 instruction lanes.
REQ-010 SHALL have port stat  in  2: ATS21 status; bit0 = A ack, bit1 = B ack.
REQ-011 SHALL have port resp_valid  out  1: a transaction result is available.
REQ-012 SHALL have port resp_ready  in  1: the consumer accepts the result.
REQ-013 SHALL have port resp  out  4: {b_issued, b_ack, a_issued, a_ack}.

Function
REQ-014 SHALL hold one command per client in a slot; a slot loads on valid&&ready, and ready = slot empty.
REQ-015 SHALL run FSM IDLE->HI->LO->WAIT->RESP->IDLE, one state per cycle except WAIT (STAT_LAT cycles) and RESP (held until resp_ready).
REQ-016 SHALL leave IDLE when either slot is full; both full slots travel in the same transaction, and it SHALL NOT wait for the second client.
REQ-017 SHALL, in HI, drive req=1 and ctrlX=cmd[31:16] for each launched lane; any lane not launched SHALL be 16'h0000.
REQ-018 SHALL, in LO, drive req=1 and ctrlX=cmd[15:0] for each launched lane.
REQ-019 SHALL drive req=0 and both lanes 16'h0000 in IDLE, WAIT and RESP.
REQ-020 SHALL treat a slot whose opcode equals OPC_NOP as launched-but-not-issued: lanes are 0, issued=0, ack=0, and the slot is freed.
REQ-021 SHALL sample stat on the last WAIT edge; ack=stat bit for issued lanes, else 0.
REQ-022 SHALL free launched slots on entry to WAIT, so a new command may load while a transaction is in WAIT/RESP.
REQ-023 SHALL assert resp_valid throughout RESP with resp stable; resp_valid&&resp_ready moves to IDLE.
REQ-024 SHALL cause a slot that fills during HI/LO to wait for the next transaction; its lane SHALL NOT change mid-transaction.
REQ-025 SHALL have minimum transaction length 4+STAT_LAT-1 cycles when resp_ready is held high.

Reset
REQ-026 SHALL, while reset is high, force FSM=IDLE, both slots empty, and req=0, ctrlA=ctrlB=0, resp_valid=0, resp=0, a_ready=b_ready=0.
REQ-027 SHALL have a_ready=b_ready=1 on the first edge after reset deasserts.
REQ-028 SHALL abandon a transaction when reset asserts mid-transaction, with no response produced and held commands lost.

Structure
REQ-029 SHALL place the opcode enum (NOP, SET_CLK, EN_CLK, MODE, SET_ALM, SET_TMR, EN_ALM), the FSM state enum and the resp bit positions in shared package ats21_pkg.
REQ-030 SHALL instantiate sub-module ats_cmd_slot (32-bit holding register with valid/ready and free input) twice, once per client.

Verification
REQ-031 SHALL cover: A cmd 32'h2200_0005 only, stat=2'b01 -> req high 2 cycles, ctrlA 16'h2200 then 16'h0005, ctrlB 0, resp=4'b0011.
REQ-032 SHALL cover: A 32'hA301_0010 and B 32'hA401_0020 offered the same cycle, stat=2'b11 -> one transaction, ctrlA 16'hA301/16'h0010, ctrlB 16'hA401/16'h0020, resp=4'b1111.
REQ-033 SHALL cover: B cmd 32'h0000_1234 (NOP) -> req stays 0, resp=4'b0000, b_ready high again after RESP.
REQ-034 SHALL cover: resp_ready low 5 cycles -> resp_valid and resp stable, req=0, and a new A command loads during the stall.
REQ-035 SHALL cover: reset pulse during LO -> all outputs 0 next cycle, no resp_valid, slots empty.
REQ-036 SHALL cover: A offered during HI of a B transaction -> A launched in the following transaction only, and A's HI lane is 0 during the current one.
